hilo_muldiv_unit: RTL

Parametrised successor to the HI/LO register unit: holds the HI and LO architectural registers and adds an iterative multiply/divide engine. It supports signed and unsigned multiply, divide and multiply-accumulate/subtract, plus direct moves to HI/LO. It sits beside the ALU in the EX stage. Busy interlocks MFHI/MFLO and further mul/div issue in the hazard unit.

---
 rtl/hilo_pkg.sv | 46 ++++
 rtl/hilo_muldiv_unit_iter.sv | 102 ++++++++++
 rtl/hilo_muldiv_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op codes, FSM states
// and small op-classification helpers.
package hilo_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_MADD  = 4'd2,
        OP_MADDU = 4'd3,
        OP_MSUB  = 4'd4,
        OP_MSUBU = 4'd5,
        OP_DIV   = 4'd6,
        OP_DIVU  = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } hilo_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } hilo_state_t;

    function automatic logic is_signed_op(hilo_op_t op);
        case (op)
            OP_MULT, OP_MADD, OP_MSUB, OP_DIV: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(hilo_op_t op);
        case (op)
            OP_DIV, OP_DIVU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic is_iter_op(hilo_op_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_iter.sv
// Iterative datapath: shift-add multiply and restoring divide on operand
// magnitudes, one bit per step, with combinational sign fix-up outputs.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     upper,
    input  logic [WIDTH-1:0]     lower,
    output logic                 last,
    output logic [2*WIDTH-1:0]   prod,
    output logic [WIDTH-1:0]     quot,
    output logic [WIDTH-1:0]     rem,
    output logic                 div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    // acc_hi/acc_lo form one shift register: product high/low for multiply,
    // partial remainder / dividend-then-quotient for divide.
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   raw_upper;
    logic               div_q;
    logic               neg_a;
    logic               neg_b;
    logic               zero_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_mag;

    // Operand magnitudes and the single add/subtract step of each algorithm.
    always_comb begin
        a_mag     = (is_signed && upper[WIDTH-1]) ? -upper : upper;
        b_mag     = (is_signed && lower[WIDTH-1]) ? -lower : lower;
        mul_sum   = acc_hi + {1'b0, (acc_lo[0] ? opnd : '0)};
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    end

    // Latch operands on load, then advance one bit per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            raw_upper <= '0;
            div_q     <= 1'b0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            zero_q    <= 1'b0;
        end else if (load) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= is_div ? a_mag : b_mag;
            opnd      <= is_div ? b_mag : a_mag;
            raw_upper <= upper;
            div_q     <= is_div;
            neg_a     <= is_signed & upper[WIDTH-1];
            neg_b     <= is_signed & lower[WIDTH-1];
            zero_q    <= is_div & (lower == '0);
        end else if (step) begin
            cnt <= cnt + CW'(1);
            if (div_q) begin
                if (!div_diff[WIDTH+1]) begin
                    acc_hi <= div_diff[WIDTH:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift;
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= {1'b0, mul_sum[WIDTH:1]};
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    // Sign-corrected results; divide-by-zero overrides the quotient/remainder.
    always_comb begin
        last     = (cnt == LAST_CNT);
        prod_mag = {acc_hi[WIDTH-1:0], acc_lo};
        prod     = (neg_a ^ neg_b) ? -prod_mag : prod_mag;
        quot     = zero_q ? '1 : ((neg_a ^ neg_b) ? -acc_lo : acc_lo);
        rem      = zero_q ? raw_upper
                          : (neg_a ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0]);
        div_zero = zero_q;
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO architectural registers with an iterative multiply/divide engine,
// issue handshake FSM and combinational read mux.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] Upper,
    input  logic [WIDTH-1:0] Lower,
    input  logic             HiLoSel,
    output logic [WIDTH-1:0] HiLoOut,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    hilo_op_t           op_in;
    hilo_op_t           op_q;
    hilo_state_t        state_q;
    hilo_state_t        state_d;
    logic               accept;
    logic               load_iter;
    logic               step_iter;
    logic               write_back;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               div_zero_q;

    logic               iter_last;
    logic [2*WIDTH-1:0] iter_prod;
    logic [WIDTH-1:0]   iter_quot;
    logic [WIDTH-1:0]   iter_rem;
    logic               iter_div_zero;
    logic [2*WIDTH-1:0] hilo_cur;
    logic [2*WIDTH-1:0] hilo_res;

    assign op_in  = hilo_op_t'(Op);
    assign accept = Start && (state_q == ST_IDLE);

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk       (Clk),
        .reset     (Reset),
        .load      (load_iter),
        .step      (step_iter),
        .is_div    (is_div_op(op_in)),
        .is_signed (is_signed_op(op_in)),
        .upper     (Upper),
        .lower     (Lower),
        .last      (iter_last),
        .prod      (iter_prod),
        .quot      (iter_quot),
        .rem       (iter_rem),
        .div_zero  (iter_div_zero)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and engine control strobes.
    always_comb begin
        state_d    = state_q;
        load_iter  = 1'b0;
        step_iter  = 1'b0;
        write_back = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_iter_op(op_in)) begin
                    load_iter = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                step_iter = 1'b1;
                if (iter_last) state_d = ST_FIX;
            end
            ST_FIX: begin
                write_back = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Final HI:LO value for the op in flight, including accumulate/subtract.
    always_comb begin
        hilo_cur = {hi_q, lo_q};
        hilo_res = hilo_cur;
        case (op_q)
            OP_MULT, OP_MULTU: hilo_res = iter_prod;
            OP_MADD, OP_MADDU: hilo_res = hilo_cur + iter_prod;
            OP_MSUB, OP_MSUBU: hilo_res = hilo_cur - iter_prod;
            OP_DIV,  OP_DIVU:  hilo_res = {iter_rem, iter_quot};
            default:           hilo_res = hilo_cur;
        endcase
    end

    // HI/LO, Done pulse and sticky divide-by-zero flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            op_q       <= OP_MULT;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= write_back;
            if (accept) begin
                div_zero_q <= 1'b0;
                if (op_in == OP_MTHI) hi_q <= Upper;
                if (op_in == OP_MTLO) lo_q <= Upper;
                if (is_iter_op(op_in)) op_q <= op_in;
            end else if (write_back) begin
                {hi_q, lo_q} <= hilo_res;
                if (iter_div_zero) div_zero_q <= 1'b1;
            end
        end
    end

    // Outputs.
    always_comb begin
        HiLoOut = HiLoSel ? hi_q : lo_q;
        Busy    = (state_q != ST_IDLE);
        Done    = done_q;
        DivZero = div_zero_q;
    end

endmodule
